// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} sa_state_e;

  localparam int SA_DEFAULT_WIDTH = 8;

  // Bit-count register width; a 1-bit adder still needs a 1-bit counter.
  function automatic int sa_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder cell driven by the serial adder controller.
module serial_fa_cell (
  input  logic cin,
  input  logic a,
  input  logic b,
  output logic cout,
  output logic sum
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller: feeds one full-adder cell LSB-first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = sa_cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sa_state_e state, state_next;

  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_shifted;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cell_sum, cell_cout;
  logic             load, last;

  serial_fa_cell u_cell (
    .cin  (carry),
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cout (cell_cout),
    .sum  (cell_sum)
  );

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    sum_shifted            = sum_sh >> 1;
    sum_shifted[WIDTH-1]   = cell_sum;
    state_next             = state;
    load                   = 1'b0;
    last                   = 1'b0;
    busy                   = 1'b0;
    done                   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) begin
          last       = 1'b1;
          state_next = FINISH;
        end
      end
      FINISH: begin
        done = 1'b1;
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all state updates here are non-blocking so every flop samples the
  // pre-edge values (e.g. the carry into the MSB used for overflow below).
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (load) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        carry  <= cell_cout;
        sum_sh <= sum_shifted;
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        cnt    <= cnt + CW'(1);
        // Result registers only move on the final bit, never showing partials.
        if (last) begin
          sum  <= sum_shifted;
          cout <= cell_cout;
`ifdef SERIAL_ADD_OVF_EN
          ovf  <= carry ^ cell_cout;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8); checks OVF when
// SERIAL_ADD_OVF_EN is defined.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, cin;
  logic [7:0] a, b, sum;
  logic       busy, done, cout;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: integer addition for the unsigned result, signed-range test for overflow.
  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mc);
    int total, ssum;
    logic [7:0] s;
    logic co, ov;
    total = int'(ma) + int'(mb) + int'(mc);
    ssum  = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
    s     = total[7:0];
    co    = (total > 255);
    ov    = (ssum > 127) || (ssum < -128);
    return {ov, co, s};
  endfunction

  task automatic check_result(input string tag, input logic [7:0] es, input logic ec, input logic eo);
    check({tag, " sum"}, 32'(sum), 32'(es));
    check({tag, " cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
`endif
  endtask

  // Start one op, scramble inputs after acceptance, then wait for DONE.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input string tag);
    int lat, nbusy;
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    lat = 0; nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, " latency"}, 32'(lat), 32'd8);
    check({tag, " busy cycles"}, 32'(nbusy), 32'd8);
  endtask

  initial begin
    int k, last_k, npulse;
    logic [9:0] m;
    logic [7:0] ra, rb;
    logic rc;

    tbl[0] = '{8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[6] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[7] = '{8'h01, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check_result("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, $sformatf("vec%0d", i));
      check_result($sformatf("vec%0d", i), tbl[i].sum, tbl[i].cout, tbl[i].ovf);
    end

    // START and new operands during RUN must be ignored.
    @(negedge clk);
    a = 8'hA5; b = 8'h3C; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b1;
    k = 0;
    while (!done && k < 40) begin
      if (k == 5) start = 1'b0;
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    check("ignore latency", 32'(k), 32'd8);
    check_result("ignore", 8'hE1, 1'b0, 1'b0);
    @(negedge clk);
    check("ignore idle busy", 32'(busy), 32'd0);

    // Reset on the 4th RUN edge aborts the op.
    @(negedge clk);
    a = 8'hA5; b = 8'h3C; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort sum", 32'(sum), 32'd0);
    npulse = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) npulse++;
    end
    check("abort no done", 32'(npulse), 32'd0);
    do_op(8'h01, 8'h01, 1'b0, "after abort");
    check_result("after abort", 8'h02, 1'b0, 1'b0);

    // Back-to-back with START held high.
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    k = 0; last_k = -1; npulse = 0;
    repeat (40) begin
      @(negedge clk);
      check($sformatf("b2b busy/done edge%0d", k), 32'(busy ^ done), 32'd1);
      if (done) begin
        npulse++;
        check($sformatf("b2b sum edge%0d", k), 32'(sum), 32'h30);
        check($sformatf("b2b period edge%0d", k), 32'(k - last_k), 32'd9);
        last_k = k;
      end
      @(posedge clk);
      k++;
    end
    check("b2b pulses", 32'(npulse), 32'd4);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      m = model(ra, rb, rc);
      do_op(ra, rb, rc, $sformatf("rand%0d", i));
      check_result($sformatf("rand%0d %h+%h+%b", i, ra, rb, rc), m[7:0], m[8], m[9]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
